// File: rtl/cipher_iterative.sv
// Iterative AES forward cipher: one round per clock over an externally expanded key schedule,
// with a start/busy/done handshake and a result register held until the next completion.
module cipher_iterative #(
    parameter int Nk = 4,
    localparam int Nr = Nk + 6
) (
    input  logic                   clks,
    input  logic                   reset,
    input  logic                   start,
    input  logic [0:127]           plainText,
    input  logic [0:128*(Nr+1)-1]  keys,
    output logic [0:127]           cipherText,
    output logic                   busy,
    output logic                   done
);

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, ROUNDS} fsm_t;

    fsm_t         fsm_q;
    logic [3:0]   round_q;
    logic [0:127] state_q;
    logic [0:127] cipher_q;
    logic         busy_q;
    logic         done_q;

    logic [0:127] sub_s;
    logic [0:127] shift_s;
    logic [0:127] mix_s;
    logic [0:127] rk_s;
    logic [0:127] round_d;
    logic [0:127] final_d;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:31] mix_col(input logic [0:31] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[0:7];
        a1 = col[8:15];
        a2 = col[16:23];
        a3 = col[24:31];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // State is column-major: byte index = row + 4*column, byte 0 in the MSBs.
    always_comb begin
        sub_s   = '0;
        shift_s = '0;
        mix_s   = '0;
        rk_s    = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            sub_s[8*i +: 8] = sbox(state_q[8*i +: 8]);
        end
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                shift_s[8*(r+4*c) +: 8] = sub_s[8*(r+4*((c+r)%4)) +: 8];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            mix_s[32*c +: 32] = mix_col(shift_s[32*c +: 32]);
        end
        for (int unsigned i = 0; i < Nr + 1; i++) begin
            if (32'(round_q) == i) begin
                rk_s = keys[128*i +: 128];
            end
        end
        round_d = mix_s ^ rk_s;
        final_d = shift_s ^ rk_s;
    end

    always_ff @(posedge clks) begin
        if (reset) begin
            fsm_q    <= IDLE;
            round_q  <= '0;
            state_q  <= '0;
            cipher_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= plainText ^ keys[0:127];
                        round_q <= 4'd1;
                        busy_q  <= 1'b1;
                        fsm_q   <= ROUNDS;
                    end
                end
                ROUNDS: begin
                    if (round_q == 4'(Nr)) begin
                        cipher_q <= final_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        round_q  <= '0;
                        fsm_q    <= IDLE;
                    end else begin
                        state_q <= round_d;
                        round_q <= round_q + 4'd1;
                    end
                end
            endcase
        end
    end

    assign cipherText = cipher_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_cipher_iterative.sv
// Bench for cipher_iterative: AES-128/192/256 instances against FIPS-197 vectors and an
// arithmetic reference model (S-box from GF inverse + affine map, key expansion, rounds).
module tb_cipher_iterative;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    start;
    logic [0:127]  pt;
    logic [0:1919] kbus;
    logic [0:127]  ct [3];
    logic [2:0]    busy;
    logic [2:0]    done;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [256];

    always #5 clk = ~clk;

    cipher_iterative #(.Nk(4)) u_aes128 (
        .clks(clk), .reset(reset), .start(start[0]), .plainText(pt), .keys(kbus[0:1407]),
        .cipherText(ct[0]), .busy(busy[0]), .done(done[0]));
    cipher_iterative #(.Nk(6)) u_aes192 (
        .clks(clk), .reset(reset), .start(start[1]), .plainText(pt), .keys(kbus[0:1663]),
        .cipherText(ct[1]), .busy(busy[1]), .done(done[1]));
    cipher_iterative #(.Nk(8)) u_aes256 (
        .clks(clk), .reset(reset), .start(start[2]), .plainText(pt), .keys(kbus[0:1919]),
        .cipherText(ct[2]), .busy(busy[2]), .done(done[2]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [0:1919] out = '0;
        int            nwords = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < nwords; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nwords; i++) out[32*i +: 32] = w[i];
        return out;
    endfunction

    function automatic logic [0:127] encrypt(input logic [0:127] p, input logic [0:1919] ks,
                                             input int nk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] res;
        int           nr = nk + 6;
        for (int i = 0; i < 16; i++) s[i] = p[8*i +: 8] ^ ks[8*i +: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row + 4*col] = t[row + 4*((col + row) % 4)];
            if (r < nr) begin
                for (int col = 0; col < 4; col++) begin
                    a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                    s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*r + 8*i +: 8];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    // One operation on instance idx; poke >= 0 re-asserts start for one cycle mid-run.
    task automatic run_op(input int idx, input logic [0:127] p, input logic [0:127] exp,
                          input string tag, input int poke);
        int nr = 4 + 2*idx + 6;
        int k  = 0;
        bit got = 1'b0;
        @(negedge clk);
        pt = p;
        start[idx] = 1'b1;
        @(posedge clk);
        while (!got && k <= nr + 3) begin
            @(negedge clk);
            start[idx] = (k == poke);
            if (done[idx]) begin
                got = 1'b1;
            end else begin
                check({tag, " busy"}, 128'(busy[idx]), 128'(1));
                @(posedge clk);
                k++;
            end
        end
        start[idx] = 1'b0;
        check({tag, " done seen"}, 128'(got), 128'(1));
        check({tag, " latency"}, 128'(k), 128'(nr));
        check({tag, " result"}, ct[idx], exp);
        check({tag, " busy at done"}, 128'(busy[idx]), 128'(0));
        @(negedge clk);
        check({tag, " done width"}, 128'(done[idx]), 128'(0));
        check({tag, " result held"}, ct[idx], exp);
    endtask

    task automatic no_done(input int idx, input int cycles, input logic [0:127] exp,
                           input string tag);
        repeat (cycles) begin
            @(negedge clk);
            check({tag, " done"}, 128'(done[idx]), 128'(0));
            check({tag, " busy"}, 128'(busy[idx]), 128'(0));
            check({tag, " ct"}, ct[idx], exp);
        end
    endtask

    initial begin
        logic [0:255] key_b, key_c4, key_c6, key_c8, rkey;
        logic [0:127] pt_b, pt_c, ct_b, ct_c, rpt;
        int           first, second;

        key_b  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        key_c4 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        key_c6 = {128'h000102030405060708090a0b0c0d0e0f, 64'h1011121314151617, 64'h0};
        key_c8 = {128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f};
        pt_b   = 128'h3243f6a8885a308d313198a2e0370734;
        pt_c   = 128'h00112233445566778899aabbccddeeff;
        ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
        ct_c   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        reset = 1'b1;
        start = '0;
        pt    = '0;
        kbus  = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) no_done(i, 20, 128'h0, "idle after reset");

        kbus = expand(key_b, 4);
        run_op(0, pt_b, ct_b, "appB", -1);
        kbus = expand(key_c4, 4);
        run_op(0, pt_c, ct_c, "appC1 nk4", -1);
        kbus = expand(key_c6, 6);
        run_op(1, pt_c, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "appC2 nk6", -1);
        kbus = expand(key_c8, 8);
        run_op(2, pt_c, 128'h8ea2b7ca516745bfeafc49904b496089, "appC3 nk8", -1);

        for (int idx = 0; idx < 3; idx++) begin
            for (int n = 0; n < 3; n++) begin
                for (int w = 0; w < 8; w++) rkey[32*w +: 32] = $urandom;
                for (int w = 0; w < 4; w++) rpt[32*w +: 32] = $urandom;
                kbus = expand(rkey, 4 + 2*idx);
                run_op(idx, rpt, encrypt(rpt, kbus, 4 + 2*idx), "random", -1);
            end
        end

        // Back-to-back: start held high through the first done.
        kbus = expand(key_b, 4);
        first = -1;
        second = -1;
        @(negedge clk);
        pt = pt_b;
        start[0] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40 && second < 0; n++) begin
            @(negedge clk);
            if (first >= 0 && n == first + 1) start[0] = 1'b0;
            if (done[0]) begin
                if (first < 0) begin
                    first = n;
                    check("b2b first result", ct[0], ct_b);
                    kbus = expand(key_c4, 4);
                    pt = pt_c;
                end else begin
                    second = n;
                    check("b2b second result", ct[0], ct_c);
                end
            end else if (first >= 0) begin
                check("b2b hold", ct[0], ct_b);
            end
            if (second < 0) @(posedge clk);
        end
        start[0] = 1'b0;
        check("b2b first latency", 128'(first), 128'(11));
        check("b2b spacing", 128'(second - first), 128'(11));
        @(negedge clk);
        check("b2b done width", 128'(done[0]), 128'(0));

        kbus = expand(key_c4, 4);
        run_op(0, pt_c, ct_c, "start while busy", 5);
        no_done(0, 16, ct_c, "after ignored start");

        // Abort at round 4.
        kbus = expand(key_b, 4);
        @(negedge clk);
        pt = pt_b;
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort busy", 128'(busy[0]), 128'(0));
        check("abort done", 128'(done[0]), 128'(0));
        check("abort ct", ct[0], 128'h0);
        reset = 1'b0;
        no_done(0, 20, 128'h0, "after abort");
        run_op(0, pt_b, ct_b, "after abort run", -1);

        // reset and start on the same edge.
        kbus = expand(key_c6, 6);
        @(negedge clk);
        reset = 1'b1;
        start[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start[1] = 1'b0;
        no_done(1, 16, 128'h0, "reset beats start");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cipher_iterative.md
# cipher_iterative

Iterative AES forward cipher (encryption): one 128-bit block per operation, one round per clock, using a fully expanded key schedule supplied by the key-expansion logic. It is the encrypt-direction counterpart of the team's iterative decryption core and accepts the same key-bus layout, so both can share one expanded-key source. A start/busy/done handshake replaces free-running operation, so the block can sit behind a bus wrapper or a block-mode controller.

## Interface
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).
- Nr, Nk+6, number of rounds; derived, not overridden.
- clks  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- plainText  in  128  input block, bit 0 = MSB = state byte 0; sampled only on the accepting edge.
- keys  in  128*(Nr+1)  expanded schedule; round key i = keys[128*i : 128*i+127]; key 0 occupies keys[0:127]; must be stable while busy=1.
- cipherText  out  128  result; updated only on completion, held otherwise.
- busy  out  1  high from the accepting edge through the final-round edge.
- done  out  1  one-cycle pulse; cipherText is valid in the same cycle.

## Operation
- Self-contained datapath:
  - 16 combinational forward S-boxes.
  - ShiftRows, with row r rotated left by r bytes (column-major state, FIPS-197 byte order).
  - MixColumns using xtime in GF(2^8), polynomial 0x11B.
  - 128-bit XOR AddRoundKey.
- Registers:
  - state[0:127]
  - round[3:0], 4 bits, enough for Nr ≤ 14
  - fsm (IDLE, ROUNDS)
  - cipherText, busy, done
- IDLE:
  - On start=1: state ← plainText ^ keys[0:127]; round ← 1; busy ← 1; fsm → ROUNDS.
  - Otherwise hold all registers; done ← 0.
- ROUNDS, round < Nr:
  - state ← AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[round]).
  - round ← round+1.
- ROUNDS, round == Nr (final round, no MixColumns):
  - cipherText ← AddRoundKey(ShiftRows(SubBytes(state)), rk[Nr]).
  - done ← 1; busy ← 0; round ← 0; fsm → IDLE.
- Round-key select: keys[128*round +: 128]. Index arithmetic is at least 12 bits wide so 128*14 does not overflow.
- start while busy=1 is ignored, not queued.
- Reset, including mid-operation: fsm=IDLE, round=0, state=0, cipherText=0, busy=0, done=0. An aborted operation produces no done.

## Timing
- Edge E0 samples start=1 in IDLE.
- Edges E1..E(Nr-1) perform rounds 1..Nr-1.
- Edge E(Nr) performs the final round.
- busy is high in cycles E0+..E(Nr)−. done and the new cipherText are visible in the cycle after E(Nr).
- Latency from the start-sampling edge to done high is Nr cycles: 10, 12 or 14.
- Back-to-back operation: start may be high in the done cycle. It is accepted at the next edge because fsm is IDLE. Throughput is one block per Nr+1 cycles.
- done is high for exactly one cycle. cipherText holds its value through any following operation until that operation's done.
- plainText may change any time after E0. keys must not change while busy=1.
- reset asserted on the same edge as start: reset wins, and the operation is not accepted.

## Test plan
- Nk=4, FIPS-197 App. B: plainText 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c (bench-expanded) -> done exactly 10 cycles after the start edge, cipherText 3925841d02dc09fbdc118597196a0b32.
- Nk=4, App. C.1: plainText 00112233445566778899aabbccddeeff, key 000102…0f -> 69c4e0d86a7b0430d8cdb78070b4c55a. Rerun with Nk=6 (key 00…17) -> dda97ca4864cdfe06eaf70a0ec0d7191, done at 12 cycles. Rerun with Nk=8 (key 00…1f) -> 8ea2b7ca516745bfeafc49904b496089, done at 14 cycles.
- Back-to-back: App. B block, then App. C.1 block with start held high through done -> two done pulses 11 cycles apart, correct results; cipherText keeps 3925…0b32 until the second done.
- start pulsed at round 5 while busy -> ignored; single done with the correct result; busy never drops early.
- reset at round 4 -> next cycle busy=0, done=0, cipherText=0; no done follows; a fresh start then completes correctly.
- After reset with no start for 20 cycles -> busy=0, done=0, cipherText=0 throughout.
